// File: rtl/ufo_scale_accum.sv
// Sign-extend and left-shift a narrow signed sample into a wide fixed-point word.
// Results are either passed through or summed in blocks. Define UFO_SAT_EN to saturate sums.
module ufo_scale_accum #(
  parameter int unsigned DATA_WIDTH_IN  = 17,
  parameter int unsigned DATA_WIDTH_OUT = 64,
  parameter int unsigned FRAC_SHIFT     = 39,
  parameter int unsigned ACC_LEN        = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enb,
  input  logic [DATA_WIDTH_IN-1:0]  i_data,
  input  logic                      i_mode,
  output logic [DATA_WIDTH_OUT-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_ovf
);

  localparam int unsigned CntW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACC_LEN - 1);
  localparam int unsigned Msb = DATA_WIDTH_OUT - 1;

  // Stage 1
  logic                      s1_valid_q;
  logic                      s1_mode_q;
  logic [DATA_WIDTH_OUT-1:0] s1_scaled_q;

  // Stage 2
  logic [DATA_WIDTH_OUT-1:0] acc_q;
  logic [CntW-1:0]           cnt_q;
  logic                      blk_mode_q;
  logic                      blk_ovf_q;
  logic [DATA_WIDTH_OUT-1:0] data_q;
  logic                      valid_q;
  logic                      ovf_out_q;

  logic [DATA_WIDTH_OUT-1:0] scaled_in;
  logic                      blk_start;
  logic                      blk_last;
  logic                      cur_mode;
  logic [DATA_WIDTH_OUT-1:0] sum;
  logic                      add_ovf;
  logic [DATA_WIDTH_OUT-1:0] sum_adj;
  logic [DATA_WIDTH_OUT-1:0] acc_d;
  logic                      blk_ovf_d;

  always_comb begin
    scaled_in = DATA_WIDTH_OUT'($signed(i_data)) << FRAC_SHIFT;
    blk_start = (cnt_q == '0);
    blk_last  = (cnt_q == CntLast);
    // The mode is latched only on the first sample of a block.
    cur_mode  = blk_start ? s1_mode_q : blk_mode_q;
    sum       = acc_q + s1_scaled_q;
    add_ovf   = (acc_q[Msb] == s1_scaled_q[Msb]) && (sum[Msb] != acc_q[Msb]);
    sum_adj   = sum;
`ifdef UFO_SAT_EN
    if (add_ovf) begin
      sum_adj = acc_q[Msb] ? {1'b1, {Msb{1'b0}}} : {1'b0, {Msb{1'b1}}};
    end
`endif
    acc_d     = blk_start ? s1_scaled_q : sum_adj;
    blk_ovf_d = blk_start ? 1'b0 : (blk_ovf_q | add_ovf);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_scaled_q <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      blk_mode_q  <= 1'b0;
      blk_ovf_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ovf_out_q   <= 1'b0;
    end else begin
      s1_valid_q <= i_enb;
      if (i_enb) begin
        s1_scaled_q <= scaled_in;
        s1_mode_q   <= i_mode;
      end

      valid_q   <= 1'b0;
      ovf_out_q <= 1'b0;
      if (s1_valid_q) begin
        blk_mode_q <= cur_mode;
        if (!cur_mode) begin
          data_q  <= s1_scaled_q;
          valid_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          acc_q     <= acc_d;
          blk_ovf_q <= blk_ovf_d;
          if (blk_last) begin
            data_q    <= acc_d;
            valid_q   <= 1'b1;
            ovf_out_q <= blk_ovf_d;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_out_q;

endmodule
